// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: control inputs from decode and the instruction-memory
// port plus the PC/valid tags that travel with the returned instruction word.
interface instruction_fetch_if;
    logic        Stall;
    logic [2:0]  PcSel;
    logic [31:0] BranchTarget;
    logic [31:0] JumpTarget;
    logic        En_I;
    logic [28:0] Addr_I;
    logic [31:0] PC_D;
    logic [31:0] PCInc_D;
    logic        Valid_D;

    modport master (
        input  Stall,
        input  PcSel,
        input  BranchTarget,
        input  JumpTarget,
        output En_I,
        output Addr_I,
        output PC_D,
        output PCInc_D,
        output Valid_D
    );

    modport slave (
        output Stall,
        output PcSel,
        output BranchTarget,
        output JumpTarget,
        input  En_I,
        input  Addr_I,
        input  PC_D,
        input  PCInc_D,
        input  Valid_D
    );
endinterface

// File: rtl/instruction_fetch.sv
// Kabeta fetch stage: owns the PC (bit 31 = supervisor), addresses the
// instruction memory and tags the word it returns one cycle later.
module instruction_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
    parameter logic [31:0] ILLOP_VECTOR = 32'h8000_0004,
    parameter logic [31:0] IRQ_VECTOR   = 32'h8000_0008
) (
    input  logic                 Clock,
    input  logic                 SysReset,
    instruction_fetch_if.master  bus
);

    localparam logic [2:0] SEL_SEQ    = 3'd0;
    localparam logic [2:0] SEL_BRANCH = 3'd1;
    localparam logic [2:0] SEL_JMP    = 3'd2;
    localparam logic [2:0] SEL_ILLOP  = 3'd3;
    localparam logic [2:0] SEL_IRQ    = 3'd4;

    logic [31:0] pc_r;
    logic [31:0] pc_d_r;
    logic        valid_d_r;
    logic [31:0] target_s;
    logic        redirect_s;
    logic        unused_s;

    // Sequential increment confined to bits [30:0]; supervisor bit passes through.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        pc_plus4 = {pc[31], pc[30:0] + 31'd4};
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        word_align = {addr[31:2], 2'b00};
    endfunction

    assign redirect_s = (bus.PcSel != SEL_SEQ);
    assign unused_s   = ^{bus.BranchTarget[31], bus.BranchTarget[1:0], bus.JumpTarget[1:0]};

    // Redirect target; a JMP can drop supervisor mode but never raise it.
    always_comb begin
        target_s = word_align(ILLOP_VECTOR);
        case (bus.PcSel)
            SEL_SEQ:    target_s = pc_plus4(pc_r);
            SEL_BRANCH: target_s = {pc_r[31], bus.BranchTarget[30:2], 2'b00};
            SEL_JMP:    target_s = {pc_r[31] & bus.JumpTarget[31], bus.JumpTarget[30:2], 2'b00};
            SEL_ILLOP:  target_s = word_align(ILLOP_VECTOR);
            SEL_IRQ:    target_s = word_align(IRQ_VECTOR);
            default:    target_s = word_align(ILLOP_VECTOR);
        endcase
    end

    // PC register and one-deep tag pipeline matching the memory read latency.
    always_ff @(posedge Clock) begin
        if (!SysReset) begin
            pc_r      <= word_align(RESET_VECTOR);
            pc_d_r    <= word_align(RESET_VECTOR);
            valid_d_r <= 1'b0;
        end else if (redirect_s) begin
            // The word in flight at the old PC is squashed.
            pc_r      <= target_s;
            pc_d_r    <= pc_r;
            valid_d_r <= 1'b0;
        end else if (bus.Stall) begin
            pc_r      <= pc_r;
            pc_d_r    <= pc_d_r;
            valid_d_r <= valid_d_r;
        end else begin
            pc_r      <= target_s;
            pc_d_r    <= pc_r;
            valid_d_r <= 1'b1;
        end
    end

    assign bus.Addr_I  = pc_r[30:2];
    assign bus.En_I    = ~bus.Stall;
    assign bus.PC_D    = pc_d_r;
    assign bus.PCInc_D = pc_plus4(pc_d_r);
    assign bus.Valid_D = valid_d_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequencing, stall, redirects,
// supervisor-bit rules, user wrap and mid-run reset.
module tb_instruction_fetch;

    logic Clock;
    logic SysReset;
    int   n_checks;
    int   n_errors;

    instruction_fetch_if bus ();

    instruction_fetch dut (
        .Clock    (Clock),
        .SysReset (SysReset),
        .bus      (bus.master)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] pcd, input logic vld);
        check_val({tag, ".pc_d"}, bus.PC_D, pcd);
        check_val({tag, ".valid"}, {31'd0, bus.Valid_D}, {31'd0, vld});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        SysReset = 1'b0;
        bus.Stall = 1'b1;
        bus.PcSel = 3'd2;
        bus.BranchTarget = 32'h0;
        bus.JumpTarget = 32'h0;
        step();
        step();
        check_out("reset", 32'h8000_0000, 1'b0);
        check_val("reset.addr", {3'd0, bus.Addr_I}, 32'h0);
        check_val("reset.en_stall", {31'd0, bus.En_I}, 32'd0);
        bus.Stall = 1'b0;
        bus.PcSel = 3'd0;
        #1;
        check_val("reset.en", {31'd0, bus.En_I}, 32'd1);

        SysReset = 1'b1;
        step();
        check_out("run0", 32'h8000_0000, 1'b1);
        check_val("run0.inc", bus.PCInc_D, 32'h8000_0004);
        check_val("run0.addr", {3'd0, bus.Addr_I}, 32'd1);
        step();
        check_out("run1", 32'h8000_0004, 1'b1);
        check_val("run1.addr", {3'd0, bus.Addr_I}, 32'd2);

        bus.Stall = 1'b1;
        #1;
        check_val("stall.en", {31'd0, bus.En_I}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("stall", 32'h8000_0004, 1'b1);
            check_val("stall.addr", {3'd0, bus.Addr_I}, 32'd2);
        end
        bus.Stall = 1'b0;
        step();
        check_out("resume0", 32'h8000_0008, 1'b1);
        step();
        check_out("resume1", 32'h8000_000C, 1'b1);

        bus.PcSel = 3'd1;
        bus.BranchTarget = 32'h0000_0100;
        step();
        check_out("br.bubble", 32'h8000_0010, 1'b0);
        check_val("br.addr", {3'd0, bus.Addr_I}, 32'h40);
        bus.PcSel = 3'd0;
        step();
        check_out("br.target", 32'h8000_0100, 1'b1);

        bus.PcSel = 3'd2;
        bus.JumpTarget = 32'h0000_0200;
        step();
        check_out("jmp_sv.bubble", 32'h8000_0104, 1'b0);
        bus.PcSel = 3'd0;
        step();
        check_out("jmp_sv.target", 32'h0000_0200, 1'b1);

        bus.PcSel = 3'd2;
        bus.JumpTarget = 32'h8000_0040;
        step();
        bus.PcSel = 3'd0;
        step();
        check_out("jmp_user.target", 32'h0000_0040, 1'b1);

        // From user mode, a branch keeps bit 31 clear.
        bus.PcSel = 3'd1;
        bus.BranchTarget = 32'hFFFF_FFFC;
        step();
        bus.PcSel = 3'd0;
        step();
        check_out("wrap.pre", 32'h7FFF_FFFC, 1'b1);
        check_val("wrap.inc", bus.PCInc_D, 32'h0000_0000);
        step();
        check_out("wrap.post", 32'h0000_0000, 1'b1);

        bus.PcSel = 3'd4;
        bus.Stall = 1'b1;
        #1;
        check_val("irq.en", {31'd0, bus.En_I}, 32'd0);
        step();
        check_val("irq.valid", {31'd0, bus.Valid_D}, 32'd0);
        bus.PcSel = 3'd0;
        bus.Stall = 1'b0;
        step();
        check_out("irq.target", 32'h8000_0008, 1'b1);

        bus.PcSel = 3'd6;
        bus.Stall = 1'b1;
        step();
        bus.PcSel = 3'd0;
        bus.Stall = 1'b0;
        step();
        check_out("sel6.target", 32'h8000_0004, 1'b1);

        bus.PcSel = 3'd3;
        step();
        bus.PcSel = 3'd0;
        step();
        check_out("illop.target", 32'h8000_0004, 1'b1);
        step();
        check_out("illop.next", 32'h8000_0008, 1'b1);

        SysReset = 1'b0;
        bus.PcSel = 3'd1;
        step();
        check_out("midreset", 32'h8000_0000, 1'b0);
        check_val("midreset.addr", {3'd0, bus.Addr_I}, 32'h0);
        SysReset = 1'b1;
        bus.PcSel = 3'd0;
        step();
        check_out("postreset", 32'h8000_0000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
